// File: rtl/ppm_slot_ctrl.sv
// ppm_slot_ctrl: PPM slot/symbol timing controller, re-aligned to the pulse stream.
// Hunts for a sync pulse, then samples each slot at mid-point and emits one
// symbol per frame with error and lock status.
// Ports: clk, rst_n (async, active-low), en, ppm_in (async line);
//        sym_valid/sym_data/sym_err (symbol result), locked, slot_clk, err_cnt.
// Optional: define PPM_ERRCNT_EN to build the saturating 8-bit symbol error
//           counter on err_cnt; otherwise err_cnt is tied to 0.
module ppm_slot_ctrl #(
    parameter int OSR      = 16,
    parameter int SLOTS    = 4,
    parameter int MAX_MISS = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     ppm_in,
    output logic                     sym_valid,
    output logic [$clog2(SLOTS)-1:0] sym_data,
    output logic                     sym_err,
    output logic                     locked,
    output logic                     slot_clk,
    output logic [7:0]               err_cnt
);

    localparam int PW = $clog2(OSR);
    localparam int SW = $clog2(SLOTS);
    localparam int MW = (MAX_MISS > 1) ? $clog2(MAX_MISS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        SYNC = 2'd2,
        RUN  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic [1:0]      hits_q, hits_d;
    logic [MW-1:0]   miss_q, miss_d;
    logic [SW-1:0]   data_q, data_d;
    logic            vld_q, vld_d;
    logic [SW-1:0]   sdata_q, sdata_d;
    logic            serr_q, serr_d;

    logic            sync1_q, ppm_s_q, ppm_d_q;
    logic            rise;
    logic            eos;
    logic            samp;

    // Two-flop synchronizer plus a delay flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            ppm_s_q <= 1'b0;
            ppm_d_q <= 1'b0;
        end else begin
            sync1_q <= ppm_in;
            ppm_s_q <= sync1_q;
            ppm_d_q <= ppm_s_q;
        end
    end

    assign rise = ppm_s_q & ~ppm_d_q;
    assign eos  = (phase_q == PW'(OSR - 1)) && (slot_q == SW'(SLOTS - 1));
    assign samp = (phase_q == PW'(OSR / 2)) && ppm_s_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= '0;
            slot_q  <= '0;
            hits_q  <= '0;
            miss_q  <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            sdata_q <= '0;
            serr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            slot_q  <= slot_d;
            hits_q  <= hits_d;
            miss_q  <= miss_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            sdata_q <= sdata_d;
            serr_q  <= serr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        slot_d  = slot_q;
        hits_d  = hits_q;
        miss_d  = miss_q;
        data_d  = data_q;
        vld_d   = 1'b0;
        sdata_d = sdata_q;
        serr_d  = serr_q;
        if (!en) begin
            state_d = IDLE;
            phase_d = '0;
            slot_d  = '0;
            hits_d  = '0;
            miss_d  = '0;
            data_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = HUNT;
                end
                HUNT: begin
                    phase_d = '0;
                    slot_d  = '0;
                    // The edge cycle itself is phase 0 of the sync symbol.
                    if (rise) begin
                        state_d = SYNC;
                        phase_d = PW'(1);
                    end
                end
                SYNC: begin
                    // Slot and phase form one counter; wrap lands on 0/0.
                    {slot_d, phase_d} = {slot_q, phase_q} + (PW + SW)'(1);
                    if (eos) begin
                        state_d = RUN;
                        hits_d  = '0;
                        data_d  = '0;
                    end
                end
                RUN: begin
                    {slot_d, phase_d} = {slot_q, phase_q} + (PW + SW)'(1);
                    if (samp) begin
                        if (hits_q != 2'd2) hits_d = hits_q + 2'd1;
                        if (hits_q == 2'd0) data_d = slot_q;
                    end
                    if (eos) begin
                        vld_d   = 1'b1;
                        sdata_d = (hits_q != 2'd0) ? data_q : '0;
                        serr_d  = (hits_q != 2'd1);
                        hits_d  = '0;
                        data_d  = '0;
                        if (hits_q == 2'd0) begin
                            if (miss_q == MW'(MAX_MISS - 1)) begin
                                state_d = HUNT;
                                miss_d  = '0;
                            end else begin
                                miss_d = miss_q + MW'(1);
                            end
                        end else begin
                            miss_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign sym_valid = vld_q;
    assign sym_data  = sdata_q;
    assign sym_err   = serr_q;
    assign locked    = (state_q == SYNC) || (state_q == RUN);
    assign slot_clk  = locked & phase_q[PW-1];

`ifdef PPM_ERRCNT_EN
    logic [7:0] errcnt_q, errcnt_d;

    always_comb begin
        errcnt_d = errcnt_q;
        if (!en) begin
            errcnt_d = '0;
        end else if (vld_q && serr_q && (errcnt_q != 8'hFF)) begin
            errcnt_d = errcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) errcnt_q <= '0;
        else        errcnt_q <= errcnt_d;
    end

    assign err_cnt = errcnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule
